// File: rtl/change_pkg.sv
// Shared definitions for the change dispenser.
// Holds the 3-bit change code constants, the dispenser FSM state encoding and
// helpers that translate a change code into nickel units.
package change_pkg;

  // Change codes as produced by the upstream vending FSM
  localparam logic [2:0] CHG_ZERO        = 3'b000;
  localparam logic [2:0] CHG_NICKEL      = 3'b001;
  localparam logic [2:0] CHG_DIME        = 3'b010;
  localparam logic [2:0] CHG_NICKEL_DIME = 3'b011;
  localparam logic [2:0] CHG_DIME_DIME   = 3'b100;
  localparam logic [2:0] CHG_QUARTER     = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_PULSE,
    ST_GAP,
    ST_DONE,
    ST_SHORT
  } state_e;

  // Amount owed in nickel units; unused codes map to nothing owed
  function automatic logic [2:0] code_units(input logic [2:0] code);
    logic [2:0] units;
    case (code)
      CHG_ZERO:        units = 3'd0;
      CHG_NICKEL:      units = 3'd1;
      CHG_DIME:        units = 3'd2;
      CHG_NICKEL_DIME: units = 3'd3;
      CHG_DIME_DIME:   units = 3'd4;
      CHG_QUARTER:     units = 3'd5;
      default:         units = 3'd0;
    endcase
    return units;
  endfunction

  function automatic logic code_is_bad(input logic [2:0] code);
    return code > CHG_QUARTER;
  endfunction

endpackage

// File: rtl/coin_tube.sv
// Inventory counter for one coin tube.
// Ports:
//   clk, reset : clock and synchronous active-high reset (loads INIT)
//   refill     : add one coin this cycle (saturates at all-ones)
//   dec        : remove one coin this cycle (ignored at zero)
//   count      : current inventory
module coin_tube #(
  parameter int COUNT_W = 6,
  parameter int INIT    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               refill,
  input  logic               dec,
  output logic [COUNT_W-1:0] count
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [COUNT_W-1:0] cnt_q, cnt_d;

  // A coin arriving while one is ejected leaves the count unchanged
  always_comb begin
    cnt_d = cnt_q;
    if (refill && !dec) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else if (dec && !refill) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= COUNT_W'(INIT);
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/change_dispenser.sv
// Converts a change code into timed nickel/dime eject pulses, greedy dimes
// first, while tracking tube inventory and flagging shortfalls.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   change                      : change code, sampled while ready
//   refill_nickel, refill_dime  : +1 coin per high cycle
//   ready                       : idle, a code may be presented
//   eject_nickel, eject_dime    : registered solenoid drives
//   done, short, bad_code       : one-cycle status pulses
//   short_amt                   : unpaid remainder, held until next accept
//   nickel_cnt, dime_cnt        : tube inventories
module change_dispenser
  import change_pkg::*;
#(
  parameter int COUNT_W     = 6,
  parameter int NICKEL_INIT = 8,
  parameter int DIME_INIT   = 8,
  parameter int PULSE_LEN   = 2,
  parameter int GAP_LEN     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         change,
  input  logic               refill_nickel,
  input  logic               refill_dime,
  output logic               ready,
  output logic               eject_nickel,
  output logic               eject_dime,
  output logic               done,
  output logic               short,
  output logic [2:0]         short_amt,
  output logic               bad_code,
  output logic [COUNT_W-1:0] nickel_cnt,
  output logic [COUNT_W-1:0] dime_cnt
);

  localparam int TMR_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] PULSE_END = TMR_W'(PULSE_LEN - 1);
  localparam logic [TMR_W-1:0] GAP_END   = TMR_W'(GAP_LEN - 1);

  state_e           state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             coin_dime_q, coin_dime_d;
  logic             dec_nickel, dec_dime;
  logic             accept;

  logic             eject_nickel_q, eject_nickel_d;
  logic             eject_dime_q, eject_dime_d;
  logic             done_q, done_d;
  logic             short_q, short_d;
  logic [2:0]       short_amt_q, short_amt_d;
  logic             bad_code_q, bad_code_d;

  assign accept = (state_q == ST_IDLE) && (change != CHG_ZERO) && !code_is_bad(change);

  // State register plus every registered output
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      rem_q          <= '0;
      tmr_q          <= '0;
      coin_dime_q    <= 1'b0;
      eject_nickel_q <= 1'b0;
      eject_dime_q   <= 1'b0;
      done_q         <= 1'b0;
      short_q        <= 1'b0;
      short_amt_q    <= '0;
      bad_code_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      rem_q          <= rem_d;
      tmr_q          <= tmr_d;
      coin_dime_q    <= coin_dime_d;
      eject_nickel_q <= eject_nickel_d;
      eject_dime_q   <= eject_dime_d;
      done_q         <= done_d;
      short_q        <= short_d;
      short_amt_q    <= short_amt_d;
      bad_code_q     <= bad_code_d;
    end
  end

  // Next-state logic; SELECT picks a dime whenever at least two units remain
  // and a dime is in stock, otherwise falls back to a nickel.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    tmr_d       = tmr_q;
    coin_dime_d = coin_dime_q;
    dec_nickel  = 1'b0;
    dec_dime    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rem_d   = code_units(change);
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        tmr_d = '0;
        if (rem_q == 3'd0) begin
          state_d = ST_DONE;
        end else if (rem_q >= 3'd2 && dime_cnt != '0) begin
          coin_dime_d = 1'b1;
          rem_d       = rem_q - 3'd2;
          dec_dime    = 1'b1;
          state_d     = ST_PULSE;
        end else if (nickel_cnt != '0) begin
          coin_dime_d = 1'b0;
          rem_d       = rem_q - 3'd1;
          dec_nickel  = 1'b1;
          state_d     = ST_PULSE;
        end else begin
          state_d = ST_SHORT;
        end
      end
      ST_PULSE: begin
        if (tmr_q == PULSE_END) begin
          tmr_d   = '0;
          state_d = ST_GAP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_q == GAP_END) begin
          tmr_d   = '0;
          state_d = ST_SELECT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_SHORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode; ejects follow PULSE one cycle later so they are glitch-free
  always_comb begin
    eject_nickel_d = (state_q == ST_PULSE) && !coin_dime_q;
    eject_dime_d   = (state_q == ST_PULSE) && coin_dime_q;
    done_d         = (state_q == ST_DONE);
    short_d        = (state_q == ST_SHORT);
    bad_code_d     = (state_q == ST_IDLE) && code_is_bad(change);
    short_amt_d    = short_amt_q;
    if (accept)                     short_amt_d = '0;
    else if (state_q == ST_SHORT)   short_amt_d = rem_q;
  end

  coin_tube #(.COUNT_W(COUNT_W), .INIT(NICKEL_INIT)) u_nickel_tube (
    .clk    (clk),
    .reset  (reset),
    .refill (refill_nickel),
    .dec    (dec_nickel),
    .count  (nickel_cnt)
  );

  coin_tube #(.COUNT_W(COUNT_W), .INIT(DIME_INIT)) u_dime_tube (
    .clk    (clk),
    .reset  (reset),
    .refill (refill_dime),
    .dec    (dec_dime),
    .count  (dime_cnt)
  );

  assign ready        = (state_q == ST_IDLE);
  assign eject_nickel = eject_nickel_q;
  assign eject_dime   = eject_dime_q;
  assign done         = done_q;
  assign short        = short_q;
  assign short_amt    = short_amt_q;
  assign bad_code     = bad_code_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus pushes the hand-derived
// events (kind, cycle after accept, inventories, short_amt) and a monitor
// pops and compares each time the DUT raises an eject, done, short or bad_code.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] change = 3'b000;
  logic       refill_nickel = 1'b0;
  logic       refill_dime = 1'b0;
  logic       ready, eject_nickel, eject_dime, done, short, bad_code;
  logic [2:0] short_amt;
  logic [5:0] nickel_cnt, dime_cnt;

  change_dispenser dut (
    .clk           (clk),
    .reset         (reset),
    .change        (change),
    .refill_nickel (refill_nickel),
    .refill_dime   (refill_dime),
    .ready         (ready),
    .eject_nickel  (eject_nickel),
    .eject_dime    (eject_dime),
    .done          (done),
    .short         (short),
    .short_amt     (short_amt),
    .bad_code      (bad_code),
    .nickel_cnt    (nickel_cnt),
    .dime_cnt      (dime_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_NICKEL, EV_DIME, EV_DONE, EV_SHORT, EV_BAD} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       at;
    int       ncnt;
    int       dcnt;
    int       samt;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  exp_n = 8;
  int  exp_d = 8;
  int  exp_samt = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushEvent(input ev_kind_e kind, input int at, input int n, input int d, input int s);
    ev_t e;
    e.kind = kind; e.at = at; e.ncnt = n; e.dcnt = d; e.samt = s;
    exp_q.push_back(e);
  endtask

  // Pop the next expected event and compare it with what the DUT just did
  task automatic handleEvent(input ev_kind_e kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event: got kind %0d at cycle %0d, expected none", int'(kind), cyc);
    end else begin
      e = exp_q.pop_front();
      checkOutput("event_kind", int'(kind), int'(e.kind));
      checkOutput("event_cycle", cyc, e.at);
      checkOutput("event_nickel_cnt", int'(nickel_cnt), e.ncnt);
      checkOutput("event_dime_cnt", int'(dime_cnt), e.dcnt);
      checkOutput("event_short_amt", int'(short_amt), e.samt);
    end
  endtask

  // Monitor: detects rising eject edges and status pulses, checks pulse width
  logic prev_en = 1'b0, prev_ed = 1'b0;
  int   width_n = 0, width_d = 0;
  always @(negedge clk) begin
    if (eject_nickel || eject_dime)
      checkOutput("one_eject_at_a_time", int'(eject_nickel && eject_dime), 0);
    if (eject_nickel && !prev_en) handleEvent(EV_NICKEL);
    if (eject_dime && !prev_ed)   handleEvent(EV_DIME);
    if (done)     handleEvent(EV_DONE);
    if (short)    handleEvent(EV_SHORT);
    if (bad_code) handleEvent(EV_BAD);
    if (eject_nickel) width_n++;
    else if (prev_en) begin checkOutput("nickel_pulse_width", width_n, 2); width_n = 0; end
    if (eject_dime) width_d++;
    else if (prev_ed) begin checkOutput("dime_pulse_width", width_d, 2); width_d = 0; end
    prev_en = eject_nickel;
    prev_ed = eject_dime;
  end

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ready"}, int'(ready), 1);
    checkOutput({tag, "_ejects"}, int'({eject_nickel, eject_dime}), 0);
    checkOutput({tag, "_nickel_cnt"}, int'(nickel_cnt), exp_n);
    checkOutput({tag, "_dime_cnt"}, int'(dime_cnt), exp_d);
    checkOutput({tag, "_short_amt"}, int'(short_amt), exp_samt);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_n = 8; exp_d = 8; exp_samt = 0;
    checkIdle("reset");
    checkOutput("reset_pulses", int'({done, short, bad_code}), 0);
  endtask

  // Called at a negedge while idle. coins is the hand-derived payout ("D"/"N"),
  // short_rem < 0 means the request completes, else the expected remainder.
  task automatic applyStimulus(input logic [2:0] code, input string coins,
                               input int short_rem, input bit noise);
    int  base;
    int  n;
    byte c;
    base = cyc + 1;
    n = coins.len();
    if (code > 3'b101) begin
      pushEvent(EV_BAD, base, exp_n, exp_d, exp_samt);
      change = code;
      @(negedge clk);
      change = 3'b000;
      repeat (3) @(negedge clk);
    end else begin
      exp_samt = 0;
      for (int i = 0; i < n; i++) begin
        c = coins[i];
        if (c == "D") begin
          exp_d--;
          pushEvent(EV_DIME, base + 2 + 4 * i, exp_n, exp_d, 0);
        end else begin
          exp_n--;
          pushEvent(EV_NICKEL, base + 2 + 4 * i, exp_n, exp_d, 0);
        end
      end
      if (short_rem < 0) begin
        pushEvent(EV_DONE, base + 2 + 4 * n, exp_n, exp_d, 0);
      end else begin
        exp_samt = short_rem;
        pushEvent(EV_SHORT, base + 2 + 4 * n, exp_n, exp_d, short_rem);
      end
      change = code;
      @(negedge clk);
      if (noise) begin
        change = 3'b111;
        repeat (2) @(negedge clk);
        change = 3'b001;
        repeat (2) @(negedge clk);
        change = 3'b000;
        repeat (4 * n) @(negedge clk);
      end else begin
        change = 3'b000;
        repeat (4 * n + 3) @(negedge clk);
      end
    end
  endtask

  initial begin
    int base;
    @(negedge clk);
    doReset();

    $display("[TB] test 1: 15c from 8/8");
    applyStimulus(3'b011, "DN", -1, 1'b0);
    checkIdle("t1_end");

    $display("[TB] test 2: quarter from 8/8, busy codes ignored");
    doReset();
    applyStimulus(3'b101, "DDN", -1, 1'b1);
    checkIdle("t2_end");

    $display("[TB] test 3: drain dimes, then 20c in nickels");
    doReset();
    repeat (4) applyStimulus(3'b100, "DD", -1, 1'b0);
    applyStimulus(3'b100, "NNNN", -1, 1'b0);
    checkIdle("t3_end");

    $display("[TB] test 4: shortfall with dimes empty");
    applyStimulus(3'b011, "NNN", -1, 1'b0);
    applyStimulus(3'b010, "N", 1, 1'b0);
    checkIdle("t4_short");
    applyStimulus(3'b111, "", -1, 1'b0);
    applyStimulus(3'b001, "", 1, 1'b0);
    refill_nickel = 1'b1;
    @(negedge clk);
    refill_nickel = 1'b0;
    exp_n++;
    checkOutput("t4_refill_nickel", int'(nickel_cnt), exp_n);
    applyStimulus(3'b001, "N", -1, 1'b0);
    checkIdle("t4_end");

    $display("[TB] test 5: refill on decrement edge, saturation");
    doReset();
    base = cyc + 1;
    pushEvent(EV_DIME, base + 2, 8, 8, 0);
    pushEvent(EV_DONE, base + 6, 8, 8, 0);
    change = 3'b010;
    @(negedge clk);
    change = 3'b000;
    refill_dime = 1'b1;
    @(negedge clk);
    refill_dime = 1'b0;
    repeat (6) @(negedge clk);
    checkIdle("t5_net_zero");
    refill_nickel = 1'b1;
    repeat (55) @(negedge clk);
    refill_nickel = 1'b0;
    checkOutput("t5_nickel_full", int'(nickel_cnt), 63);
    refill_nickel = 1'b1;
    repeat (3) @(negedge clk);
    refill_nickel = 1'b0;
    checkOutput("t5_nickel_saturated", int'(nickel_cnt), 63);

    $display("[TB] test 6: reset mid-dispense");
    doReset();
    base = cyc + 1;
    pushEvent(EV_DIME, base + 2, 8, 7, 0);
    change = 3'b100;
    @(negedge clk);
    change = 3'b000;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_n = 8; exp_d = 8; exp_samt = 0;
    checkIdle("t6_after_reset");
    checkOutput("t6_done_low", int'(done), 0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    checkIdle("t6_end");

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
